// File: rtl/bcd_pkg.sv
// Shared BCD constants and digit validation helpers.
// Used by bcd_digit and bcd_updown_counter_n.
package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam int unsigned BCD_MAX_DIGITS = 8;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

  // v holds up to 8 packed digits; only the low n are checked
  function automatic logic bcd_all_valid(
    input logic [31:0] v,
    input int unsigned n
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < n && !bcd_digit_valid(v[4*i +: 4])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_n_digit.sv
// One BCD digit register with up/down step and parallel load.
// Ports: clk, rst, step, up, load, load_d -> q, tc_up (q==9), tc_dn (q==0).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] q,
  output logic       tc_up,
  output logic       tc_dn
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_d;
    end else if (step) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign tc_up = (q_q == BCD_MAX);
  assign tc_dn = (q_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit synchronous BCD up/down counter with validated load, zero flag,
// registered wrap pulse (cout) and load-reject pulse (load_err).
// Ports: clk, rst (sync, active-high), en, up, load, load_val -> bcd, cout,
// zero, load_err. Define BCD_SATURATE_EN to hold at the limits instead of
// wrapping; cout then pulses once per blocked step.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd,
  output logic                cout,
  output logic                zero,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [DIGITS-1:0] tc_up;
  logic [DIGITS-1:0] tc_dn;
  logic [DIGITS-1:0] sel_tc;
  logic [DIGITS:0]   chain;
  logic [31:0]       lv_ext;
  logic              lv_ok;
  logic              load_ok;
  logic              cnt_req;
  logic              at_limit;
  logic              cnt_en;
  logic              cout_q;
  logic              cout_d;
  logic              load_err_q;
  logic              load_err_d;

  assign lv_ext  = 32'(load_val);
  assign lv_ok   = bcd_all_valid(lv_ext, DIGITS);
  assign load_ok = load & lv_ok;

  // any load request, valid or not, discards the count request
  assign cnt_req = en & ~load;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      sel_tc[i] = up ? tc_up[i] : tc_dn[i];
    end
  end

  // all digits terminal in the chosen direction: the step wraps
  assign at_limit = &sel_tc;

`ifdef BCD_SATURATE_EN
  assign cnt_en = cnt_req & ~at_limit;
`else
  assign cnt_en = cnt_req;
`endif

  // digit i steps when every lower digit is terminal
  assign chain[0] = cnt_en;
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      chain[i+1] = chain[i] & sel_tc[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .clk    (clk),
        .rst    (rst),
        .step   (chain[g]),
        .up     (up),
        .load   (load_ok),
        .load_d (load_val[4*g +: 4]),
        .q      (bcd[4*g +: 4]),
        .tc_up  (tc_up[g]),
        .tc_dn  (tc_dn[g])
      );
    end
  endgenerate

  // wrap and blocked-step both pulse cout
  always_comb begin
    cout_d     = cnt_req & at_limit;
    load_err_d = load & ~lv_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cout_q     <= cout_d;
      load_err_q <= load_err_d;
    end
  end

  assign cout     = cout_q;
  assign load_err = load_err_q;
  assign zero     = &tc_dn;

  logic unused_w;
  assign unused_w = ^{W[0], lv_ext};

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed self-checking bench for bcd_updown_counter_n (DIGITS=4).
// Expected values are hand-computed constants.
module tb_bcd_updown_counter_n;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic        cout;
  logic        zero;
  logic        load_err;

  int tests;
  int fails;
  int cout_seen;

  bcd_updown_counter_n #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .cout     (cout),
    .zero     (zero),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] eb,
                         input logic ec, input logic ez, input logic ee);
    chk({tag, ".bcd"}, 32'(bcd), 32'(eb));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    chk({tag, ".lerr"}, 32'(load_err), 32'(ee));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    tick();
    rst = 1'b0;
    chk_all("reset", 16'h0000, 1'b0, 1'b1, 1'b0);

    // 12 up steps
    en = 1'b1; up = 1'b1;
    cout_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cout) cout_seen++;
    end
    en = 1'b0;
    chk_all("up12", 16'h0012, 1'b0, 1'b0, 1'b0);
    chk("up12.nocout", 32'(cout_seen), 32'd0);

    tick();
    chk_all("hold", 16'h0012, 1'b0, 1'b0, 1'b0);

    // load beats en
    load = 1'b1; load_val = 16'h9998; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    chk_all("ld9998", 16'h9998, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("up9999", 16'h9999, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("wrapup", 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("up0001", 16'h0001, 1'b0, 1'b0, 1'b0);
    en = 1'b0;

    // down wrap from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1; up = 1'b0;
    tick();
    chk_all("wrapdn", 16'h9999, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("dn9998", 16'h9998, 1'b0, 1'b0, 1'b0);

    // rejected load: hold, load_err, no step
    load = 1'b1; load_val = 16'h12A4; up = 1'b1;
    tick();
    chk_all("badld", 16'h9998, 1'b0, 1'b0, 1'b1);
    load_val = 16'hA000; en = 1'b0;
    tick();
    chk_all("badtop", 16'h9998, 1'b0, 1'b0, 1'b1);
    load_val = 16'h0500;
    tick();
    load = 1'b0;
    chk_all("ld0500", 16'h0500, 1'b0, 1'b0, 1'b0);

    // down borrow across digits, then direction change
    en = 1'b1; up = 1'b0;
    tick();
    chk_all("dn0499", 16'h0499, 1'b0, 1'b0, 1'b0);
    up = 1'b1;
    tick();
    chk_all("up0500", 16'h0500, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("up0501", 16'h0501, 1'b0, 1'b0, 1'b0);

    // rst beats load and en
    rst = 1'b1; load = 1'b1; load_val = 16'h1234; en = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    chk_all("rstpri", 16'h0000, 1'b0, 1'b1, 1'b0);

`ifdef BCD_SATURATE_EN
    load = 1'b1; load_val = 16'h9999;
    tick();
    load = 1'b0;
    chk_all("sat.ld", 16'h9999, 1'b0, 1'b0, 1'b0);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("sat.up", 16'h9999, 1'b1, 1'b0, 1'b0);
    end
    up = 1'b0;
    tick();
    chk_all("sat.dn", 16'h9998, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
`else
    // load at limit then wrap with en held: cout only on the wrap
    load = 1'b1; load_val = 16'h9999;
    tick();
    load = 1'b0;
    en = 1'b1; up = 1'b1;
    tick();
    chk_all("wrap2", 16'h0000, 1'b1, 1'b1, 1'b0);
    up = 1'b0;
    tick();
    chk_all("wrap3", 16'h9999, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    chk_all("idle", 16'h9999, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
Parametrised N-digit synchronous BCD counter, the successor to the fixed 4-digit up-only counter.
- Adds up/down counting, parallel load with BCD validation, a zero flag and a registered wrap pulse.
- Serves as the time/event counter feeding the 7-segment display multiplexer and the cascaded timer blocks.
- The whole count vector is registered; the carry chain is combinational across digits.

Parameters:
DIGITS, 4, number of BCD digits (1..8); the count vector is 4*DIGITS bits wide, with digit 0 in bits [3:0].

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable, one step per cycle while high.
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
load  input  1  synchronous parallel load request.
load_val  input  4*DIGITS  value to load, packed BCD, digit 0 in LSBs.
bcd  output  4*DIGITS  current count, registered, packed BCD.
cout  output  1  one-cycle registered pulse on wrap (or on a blocked step in saturate mode).
zero  output  1  high when bcd equals all-zero digits; combinational from the bcd register.
load_err  output  1  one-cycle registered pulse when a load is rejected.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: bcd=0, cout=0, load_err=0, so zero=1.
- Priority per cycle: rst > load > en. With none active, bcd holds and cout and load_err are 0.
- Load with every digit of load_val <= 9:
  - bcd <= load_val on the next edge.
  - load_err=0 and cout=0 in that cycle, even if en=1.
- Load with any digit > 9:
  - bcd holds and load_err=1 for exactly one cycle.
  - The en/up request in that cycle is discarded.
- Count up (en=1, up=1):
  - Digit i increments when every digit j < i equals 9.
  - A digit at 9 that increments becomes 0; a digit at 0 that decrements becomes 9.
- Count down (en=1, up=0): digit i decrements when every digit j < i equals 0.
- Wrap:
  - Up from all-9s goes to all-0s; down from all-0s goes to all-9s.
  - cout=1 on the edge that writes the wrapped value, i.e. coincident with the new bcd, for one cycle.
  - Continuous en produces a cout pulse every 10^DIGITS steps.
- Latency: a step or load becomes visible on bcd one cycle after the request edge. zero follows bcd with no extra cycle.
- Direction change: takes effect in the same cycle it is sampled. No pipeline, no hysteresis.
- Mid-operation rst overrides any simultaneous load or en.
- Illegal digit values never appear on bcd. Only validated loads and the counter logic can write bcd.

Optional Feature:
BCD_SATURATE_EN.
- Defined:
  - Up at all-9s and down at all-0s hold bcd instead of wrapping.
  - cout pulses one cycle for each blocked step, so a held en at the limit keeps cout=1 every cycle.
  - All other behaviour is unchanged.
- Undefined: wrap behaviour as above.

Decomposition:
Shared package bcd_pkg:
- localparam BCD_W=4, BCD_MAX=4'd9.
- Function bcd_digit_valid(d) returning d<=9.
- Function bcd_all_valid over a packed vector, used for load checking.

Sub-module bcd_digit:
- Behaviour: one 4-bit register with step, up, load and load_d inputs.
- Outputs its value plus tc_up (value==9) and tc_dn (value==0).
- Instantiated DIGITS times in a generate loop.

Top level:
- Builds the step chain as an AND of lower-digit tc signals, selected by up.
- Holds the cout/load_err registers and the saturate gating.

Test Plan:
1. Reset then 12 cycles en=1, up=1 (DIGITS=4) -> bcd=0x0012, zero=0, cout never asserted.
2. Load 0x9998, en=1, up=1 for 3 cycles -> bcd 0x9999, then 0x0000 with cout=1 for that single cycle, then 0x0001 with cout=0.
3. From reset, en=1, up=0 for 1 cycle -> bcd=0x9999, cout=1 for one cycle, zero drops. One more cycle -> 0x9998.
4. Load 0x12A4 with en=1 -> bcd unchanged, load_err=1 for one cycle, no count step. Then load 0x0500 -> bcd=0x0500, load_err=0.
5. Same cycle rst=1, load=1, en=1 -> bcd=0, zero=1, cout=0, load_err=0.
6. With BCD_SATURATE_EN defined, load 0x9999, en=1, up=1 for 3 cycles -> bcd stays 0x9999, cout=1 on all 3 cycles. Then up=0 -> 0x9998, cout=0.
